// File: rtl/bc_sequence_counter.sv
// ---------------------------------------------------------------------------
// bc_sequence_counter
//
// Timing sequence counter (SC) and start/stop (S) flip-flop for the Basic
// Computer control unit. The SC value feeds the 4-to-16 timing decoder
// directly (sc[0]->IN0 .. sc[3]->IN3) to produce T0..T15. The control logic
// advances, clears or halts the sequence. A busy memory stalls the sequence,
// and a watchdog aborts a stall that lasts too long. Completed instructions
// are counted.
//
// Ports:
//   clk           in   system clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   single-cycle pulse, sets S and begins execution
//   halt          in   HLT executed, clears S at the next edge
//   sc_inr        in   advance SC to the next timing state
//   sc_clr        in   clear SC to 0 (end of instruction)
//   mem_busy      in   memory not ready, SC must not advance while high
//   sc            out  current timing state, to the decoder
//   run           out  S flip-flop
//   stalled       out  high while waiting on memory
//   wrap_err      out  sticky, SC was incremented from its maximum value
//   stall_timeout out  sticky, a stall exceeded WAIT_TIMEOUT cycles
//   instr_count   out  completed instructions, modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module bc_sequence_counter #(
  parameter int SC_WIDTH     = 4,
  parameter int WAIT_TIMEOUT = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 sc_inr,
  input  logic                 sc_clr,
  input  logic                 mem_busy,
  output logic [SC_WIDTH-1:0]  sc,
  output logic                 run,
  output logic                 stalled,
  output logic                 wrap_err,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] instr_count
);

  // WAIT_TIMEOUT is at most 255, so an 8-bit stall counter always suffices.
  localparam logic [7:0] TIMEOUT_VAL = 8'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SC_WIDTH-1:0]   sc_d;
  logic                  wrap_d;
  logic                  timeout_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [7:0]            stall_q, stall_d;
  logic                  run_d;
  logic                  stalled_d;
  logic                  sc_at_max;

  // An increment from the all-ones value rolls SC over to zero and is
  // flagged as a sequencing error.
  assign sc_at_max = (sc == {SC_WIDTH{1'b1}});

  // State register. run and stalled are registered copies of the next-state
  // decode so that every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sc            <= '0;
      run           <= 1'b0;
      stalled       <= 1'b0;
      wrap_err      <= 1'b0;
      stall_timeout <= 1'b0;
      instr_count   <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      sc            <= sc_d;
      run           <= run_d;
      stalled       <= stalled_d;
      wrap_err      <= wrap_d;
      stall_timeout <= timeout_d;
      instr_count   <= cnt_d;
      stall_q       <= stall_d;
    end
  end

  // Next-state logic. Within RUN and STALL the checks are ordered by
  // priority: halt, then clear, then increment/stall handling. The pending
  // increment of a stall is implicit in being in STALL, so it is performed
  // exactly once when memory frees up, and sc_inr during the stall is moot.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc;
    wrap_d    = wrap_err;
    timeout_d = stall_timeout;
    cnt_d     = instr_count;
    stall_d   = stall_q;

    unique case (state_q)
      IDLE: begin
        sc_d    = '0;
        stall_d = '0;
        if (start) begin
          state_d   = RUN;
          wrap_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      RUN: begin
        if (halt) begin
          state_d = IDLE;
          sc_d    = '0;
          if (sc_clr) cnt_d = instr_count + CNT_WIDTH'(1);
        end else if (sc_clr) begin
          sc_d  = '0;
          cnt_d = instr_count + CNT_WIDTH'(1);
        end else if (sc_inr) begin
          if (!mem_busy) begin
            sc_d = sc + SC_WIDTH'(1);
            if (sc_at_max) wrap_d = 1'b1;
          end else begin
            state_d = STALL;
            stall_d = 8'd1;
          end
        end
      end

      STALL: begin
        if (halt) begin
          state_d = IDLE;
          sc_d    = '0;
          stall_d = '0;
        end else if (sc_clr) begin
          state_d = RUN;
          sc_d    = '0;
          cnt_d   = instr_count + CNT_WIDTH'(1);
          stall_d = '0;
        end else if (!mem_busy) begin
          state_d = RUN;
          sc_d    = sc + SC_WIDTH'(1);
          stall_d = '0;
          if (sc_at_max) wrap_d = 1'b1;
        end else if (stall_q == TIMEOUT_VAL) begin
          state_d   = IDLE;
          sc_d      = '0;
          timeout_d = 1'b1;
          stall_d   = '0;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        sc_d    = '0;
        stall_d = '0;
      end
    endcase

    run_d     = (state_d != IDLE);
    stalled_d = (state_d == STALL);
  end

endmodule

// File: tb/tb_bc_sequence_counter.sv
// ---------------------------------------------------------------------------
// tb_bc_sequence_counter
//
// Directed bench for bc_sequence_counter with WAIT_TIMEOUT=4. Each step
// drives the inputs on the falling edge, records the outputs expected after
// the next rising edge in a queue, and checks them just after that edge.
// ---------------------------------------------------------------------------
module tb_bc_sequence_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        sc_inr;
  logic        sc_clr;
  logic        mem_busy;
  logic [3:0]  sc;
  logic        run;
  logic        stalled;
  logic        wrap_err;
  logic        stall_timeout;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [3:0]  sc;
    logic        run;
    logic        stalled;
    logic        wrap_err;
    logic        stall_timeout;
    logic [15:0] instr_count;
  } obs_t;

  obs_t expected_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  bc_sequence_counter #(
    .SC_WIDTH     (4),
    .WAIT_TIMEOUT (4),
    .CNT_WIDTH    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt          (halt),
    .sc_inr        (sc_inr),
    .sc_clr        (sc_clr),
    .mem_busy      (mem_busy),
    .sc            (sc),
    .run           (run),
    .stalled       (stalled),
    .wrap_err      (wrap_err),
    .stall_timeout (stall_timeout),
    .instr_count   (instr_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Pop the oldest expectation and compare it with the current outputs
  task automatic checkOutput(input string tag);
    obs_t obs;
    obs_t exp;
    obs = '{sc: sc, run: run, stalled: stalled, wrap_err: wrap_err,
            stall_timeout: stall_timeout, instr_count: instr_count};
    compared++;
    if (expected_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = expected_q.pop_front();
      assert (obs === exp) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed sc=%0d run=%b stalled=%b wrap=%b to=%b cnt=%0d, expected sc=%0d run=%b stalled=%b wrap=%b to=%b cnt=%0d",
               tag, obs.sc, obs.run, obs.stalled, obs.wrap_err, obs.stall_timeout, obs.instr_count,
               exp.sc, exp.run, exp.stalled, exp.wrap_err, exp.stall_timeout, exp.instr_count);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then clock and check.
  task automatic applyStimulus(input logic s, input logic h, input logic i,
                               input logic c, input logic b,
                               input logic [3:0] esc, input logic erun,
                               input logic est, input logic ewr, input logic eto,
                               input logic [15:0] ecnt, input string tag);
    @(negedge clk);
    start    = s;
    halt     = h;
    sc_inr   = i;
    sc_clr   = c;
    mem_busy = b;
    expected_q.push_back('{sc: esc, run: erun, stalled: est, wrap_err: ewr,
                           stall_timeout: eto, instr_count: ecnt});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    halt     = 1'b0;
    sc_inr   = 1'b0;
    sc_clr   = 1'b0;
    mem_busy = 1'b0;

    // Reset state
    #3;
    expected_q.push_back('0);
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: start, three increments, clear
    //            s  h  i  c  b   sc run st wr to cnt
    applyStimulus(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, "t1_start");
    applyStimulus(0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, "t1_inr1");
    applyStimulus(0, 0, 1, 0, 0,  2, 1, 0, 0, 0, 0, "t1_inr2");
    applyStimulus(0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 0, "t1_inr3");
    applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1, "t1_clr");

    // 2: stall at sc=2 for three cycles, exactly one increment afterwards
    applyStimulus(0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1, "t2_inr1");
    applyStimulus(0, 0, 1, 0, 0,  2, 1, 0, 0, 0, 1, "t2_inr2");
    applyStimulus(0, 0, 1, 0, 1,  2, 1, 1, 0, 0, 1, "t2_stall1");
    applyStimulus(0, 0, 1, 0, 1,  2, 1, 1, 0, 0, 1, "t2_stall2");
    applyStimulus(0, 0, 1, 0, 1,  2, 1, 1, 0, 0, 1, "t2_stall3");
    applyStimulus(0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 1, "t2_release");
    applyStimulus(0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 1, "t2_hold");

    // 3: stall timeout at sc=5 with WAIT_TIMEOUT=4; start ignored in STALL
    applyStimulus(0, 0, 1, 0, 0,  4, 1, 0, 0, 0, 1, "t3_inr4");
    applyStimulus(0, 0, 1, 0, 0,  5, 1, 0, 0, 0, 1, "t3_inr5");
    applyStimulus(0, 0, 1, 0, 1,  5, 1, 1, 0, 0, 1, "t3_stall1");
    applyStimulus(1, 0, 0, 0, 1,  5, 1, 1, 0, 0, 1, "t3_stall2_start");
    applyStimulus(0, 0, 0, 0, 1,  5, 1, 1, 0, 0, 1, "t3_stall3");
    applyStimulus(0, 0, 0, 0, 1,  5, 1, 1, 0, 0, 1, "t3_stall4");
    applyStimulus(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, "t3_timeout");
    applyStimulus(0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1, "t3_idle_inr");
    applyStimulus(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, "t3_restart");

    // 4: sixteen increments wrap SC and set the sticky wrap flag
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 4'(k % 16), 1, 0, (k == 16), 0, 1,
                    $sformatf("t4_inr%0d", k));
    end
    applyStimulus(0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 2, "t4_clr_sticky");

    // 5: bring instr_count to 9 and sc to 7, then halt together with clear
    for (int k = 3; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 16'(k),
                    $sformatf("t5_clr%0d", k));
    end
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 4'(k), 1, 0, 1, 0, 9,
                    $sformatf("t5_inr%0d", k));
    end
    applyStimulus(0, 1, 0, 1, 0,  0, 0, 0, 1, 0, 10, "t5_halt_clr");
    applyStimulus(0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 10, "t5_idle_inr");

    // 6: restart clears wrap flag, enter a stall, reset asynchronously mid-stall
    applyStimulus(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 10, "t6_start");
    applyStimulus(0, 0, 1, 0, 1,  0, 1, 1, 0, 0, 10, "t6_stall1");
    applyStimulus(0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 10, "t6_stall2");
    #1;
    rst_n = 1'b0;
    #1;
    expected_q.push_back('0);
    checkOutput("t6_async_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    mem_busy = 1'b0;
    applyStimulus(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, "t6_inr_no_start");
    applyStimulus(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, "t6_start_again");
    applyStimulus(0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, "t6_inr");

    // Halt during a stall discards the pending increment
    applyStimulus(0, 0, 1, 0, 1,  1, 1, 1, 0, 0, 0, "t7_stall");
    applyStimulus(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, "t7_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bc_sequence_counter.md
Name: bc_sequence_counter

Overview:
- Timing sequence counter (SC) plus start/stop (S) flip-flop for the Basic Computer control unit.
- Output `sc` drives the 4-to-16 timing decoder directly: sc[0]→IN0 … sc[3]→IN3, producing T0..T15.
- Control logic issues increment, clear and halt. Memory busy stalls the sequence, with a timeout watchdog.
- Also counts completed instructions.

Parameters:
- SC_WIDTH, 4, counter width; fixed at 4 to match the 4-to-16 timing decoder.
- WAIT_TIMEOUT, 15, maximum consecutive stall cycles before fault (legal range 1..255).
- CNT_WIDTH, 16, width of the instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; sets S (begins execution).
- halt  input  1  HLT executed; clears S at the next edge.
- sc_inr  input  1  increment SC (advance to next timing state).
- sc_clr  input  1  clear SC to 0 (end of instruction).
- mem_busy  input  1  memory not ready; SC must not advance while high.
- sc  output  SC_WIDTH  current timing state, to the decoder.
- run  output  1  S flip-flop.
- stalled  output  1  high while in STALL.
- wrap_err  output  1  sticky; SC incremented from 15.
- stall_timeout  output  1  sticky; stall exceeded WAIT_TIMEOUT.
- instr_count  output  CNT_WIDTH  completed instructions, modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values (immediate on rst_n=0, regardless of clk; state=IDLE):
  - sc=0, run=0, stalled=0
  - wrap_err=0, stall_timeout=0
  - instr_count=0, stall counter=0
- Registers: all outputs are registered. Zero combinational paths from inputs to outputs.
- FSM states: IDLE, RUN, STALL.
  - run=1 in RUN and STALL.
  - stalled=1 only in STALL.
- IDLE:
  - sc held at 0; sc_inr, sc_clr, halt ignored.
  - start=1 → RUN next cycle, sc=0, and wrap_err / stall_timeout cleared on the same edge.
- RUN, priority high to low:
  - (a) halt: → IDLE, sc=0. If sc_clr is also high, instr_count increments on the same edge.
  - (b) sc_clr: sc=0, instr_count+1, stay RUN. sc_inr is ignored.
  - (c) sc_inr with mem_busy=0: sc=sc+1. From 15 it wraps to 0 and sets wrap_err; stay RUN.
  - (d) sc_inr with mem_busy=1: → STALL, sc held, increment is pending, stall counter=1.
  - (e) otherwise: hold.
  - start is ignored in RUN and in STALL.
- STALL, priority high to low:
  - (a) halt: → IDLE, sc=0, pending increment discarded.
  - (b) sc_clr: sc=0, instr_count+1, → RUN, pending increment discarded.
  - (c) mem_busy=0: perform the pending increment (same wrap rule as RUN), → RUN. Exactly one increment, regardless of stall length or of sc_inr during the stall.
  - (d) mem_busy=1 and stall counter==WAIT_TIMEOUT: set stall_timeout, → IDLE, sc=0, run=0.
  - (e) otherwise: stall counter+1, sc held.
- Stall duration: the longest legal stall is WAIT_TIMEOUT cycles with stalled=1. Timeout fires on the edge after stall counter reaches WAIT_TIMEOUT.
- sc_inr in STALL is ignored (it does not queue a second increment).
- instr_count wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Sticky flags clear only on reset or on an accepted start in IDLE.
- Reset asserted mid-instruction or mid-stall: immediate return to reset values; no pending state survives.
- Latency:
  - start → run=1: 1 cycle.
  - sc_inr → new sc: 1 cycle, absent stall.
  - mem_busy falling → sc advance: 1 cycle.

Test Plan:
1. Reset then start pulse, sc_inr high 3 cycles, then sc_clr → run=1; sc sequence 0,1,2,3, then 0; instr_count=1.
2. From sc=2, sc_inr with mem_busy high for 3 cycles, then low → stalled=1 for 3 cycles, sc held at 2, then sc=3. Exactly one increment, despite sc_inr held throughout.
3. WAIT_TIMEOUT=4, mem_busy held high after sc_inr at sc=5 → 4 stalled cycles, then stall_timeout=1, run=0, sc=0. A subsequent start clears stall_timeout.
4. sc_inr held 16 cycles from sc=0 → sc reaches 15, then 0; wrap_err=1 and it stays set through later sc_clr.
5. halt and sc_clr together at sc=7 with instr_count=9 → next cycle IDLE, run=0, sc=0, instr_count=10. Later sc_inr is ignored while IDLE.
6. rst_n pulled low asynchronously mid-stall (between clk edges) → all outputs 0 immediately. After release, sc_inr alone does not move sc until start.
